// File: rtl/nios_sys_led_pwm.sv
// rtl/nios_sys_led_pwm.sv - 16-level glitch-free LED PWM with optional linear fade
module nios_sys_led_pwm #(
    parameter int PRESCALE     = 4,
    parameter int FADE_PERIODS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] level,
    input  logic       fade_en,
    output logic       pwm_out,
    output logic [3:0] duty,
    output logic       busy,
    output logic       period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_PERIODS - 1);
    localparam logic [3:0]    PWM_LAST   = 4'd14;

    logic [PW-1:0] presc_cnt;
    logic [PW-1:0] presc_next;
    logic [3:0]    pwm_cnt;
    logic [3:0]    pwm_cnt_next;
    logic [3:0]    target;
    logic [3:0]    duty_next;
    logic [FW-1:0] fade_cnt;
    logic [FW-1:0] fade_next;
    logic          tick;
    logic          boundary;

    always_comb begin
        tick         = (presc_cnt == PRESC_LAST);
        boundary     = tick && (pwm_cnt == PWM_LAST);
        presc_next   = tick ? '0 : presc_cnt + PW'(1);
        pwm_cnt_next = pwm_cnt;
        if (tick) begin
            pwm_cnt_next = (pwm_cnt == PWM_LAST) ? 4'd0 : pwm_cnt + 4'd1;
        end

        duty_next = duty;
        fade_next = fade_cnt;
        // Direction is recomputed at every step so a new target redirects without overshoot.
        if (boundary) begin
            if (!fade_en) begin
                duty_next = target;
                fade_next = '0;
            end else if (duty == target) begin
                fade_next = '0;
            end else if (fade_cnt == FADE_LAST) begin
                duty_next = (target > duty) ? duty + 4'd1 : duty - 4'd1;
                fade_next = '0;
            end else begin
                fade_next = fade_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt    <= '0;
            pwm_cnt      <= '0;
            target       <= '0;
            duty         <= '0;
            fade_cnt     <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= presc_next;
            pwm_cnt      <= pwm_cnt_next;
            target       <= level;
            duty         <= duty_next;
            fade_cnt     <= fade_next;
            // Registering the next-state compare keeps pwm_out == (pwm_cnt < duty) every cycle.
            pwm_out      <= (pwm_cnt_next < duty_next);
            period_start <= boundary;
        end
    end

    assign busy = (duty != target);

endmodule

// File: doc/nios_sys_led_pwm.md
# nios_sys_led_pwm

Downstream consumer of the Nios system's 4-bit output PIO port. It turns the 4-bit level written by software into a 16-level, glitch-free PWM drive for a MAX1000 user LED. An optional linear fade steps the applied duty toward each new level. Duty changes take effect only at PWM period boundaries, so no period is ever truncated or stretched.

## Interface
- PRESCALE, 4, clk cycles per PWM tick; legal range ≥1.
- FADE_PERIODS, 2, PWM periods per fade step; legal range ≥1.

- clk  in  1  system clock; the PIO is on the same clock.
- reset_n  in  1  reset, synchronous and active-low (one clock; reset is synchronous active-low).
- level  in  4  target duty, 0..15, driven directly by the PIO out_port.
- fade_en  in  1  1 = step duty by ±1 every FADE_PERIODS periods; 0 = jump to target at the next boundary.
- pwm_out  out  1  LED drive; active-high.
- duty  out  4  currently applied duty.
- busy  out  1  high while duty ≠ target.
- period_start  out  1  one-cycle pulse in the first cycle of each PWM period.

## Operation
- **target**
  - 4-bit register, loaded from level on every clk edge.
  - All other logic uses target, never level directly.
- **Prescaler presc_cnt**
  - Counts 0..PRESCALE-1, then wraps.
  - tick = (presc_cnt == PRESCALE-1).
  - With PRESCALE=1, tick is high every cycle.
- **PWM counter pwm_cnt**
  - 4-bit; advances on tick; range 0..14.
  - Wraps 14→0, giving 15 ticks per period.
  - Value 15 is never reached.
- **Boundary**
  - boundary = tick && pwm_cnt == 14.
  - duty and fade_cnt change only on a boundary edge.
- **Fade disabled** (fade_en=0 at the boundary): duty ← target; fade_cnt ← 0.
- **Fade enabled** (fade_en=1 at the boundary):
  - If duty == target: fade_cnt ← 0; no step.
  - Else if fade_cnt == FADE_PERIODS-1: duty ← duty+1 if target > duty, else duty-1; fade_cnt ← 0.
  - Else: fade_cnt ← fade_cnt+1.
  - Direction is re-evaluated at every step, so a target change mid-fade reverses or redirects the fade with no overshoot.
  - Steps are ±1 with no wrap arithmetic; duty stays within 0..15.
  - Deasserting fade_en mid-fade jumps duty to target at the next boundary.
- **pwm_out**
  - Registered; each edge loads (pwm_cnt_next < duty_next).
  - As a result, pwm_out == (pwm_cnt < duty) in every cycle.
  - duty 0 gives constant low; duty 15 gives constant high.
  - For any duty d: high for d·PRESCALE cycles, then low for (15-d)·PRESCALE cycles, per period.
- **period_start**: registered; set on the boundary edge, so it is high exactly while pwm_cnt == 0 and presc_cnt == 0.
- **busy** = (duty ≠ target), derived combinationally from registers.

## Timing
- Reset (reset_n low at an edge) clears all of: presc_cnt, pwm_cnt, target, duty, fade_cnt, pwm_out, period_start.
  - Resulting outputs: pwm_out=0, duty=0, busy=0, period_start=0.
- The first period starts in the cycle after reset_n is sampled high. period_start is not asserted for that first period.
- Reset mid-fade or mid-period aborts immediately. No partial state survives.
- PWM period = 15·PRESCALE clk cycles.
- Latency from level change to target: 1 cycle. busy may rise in the cycle after level changes.
- Latency to duty with fade_en=0: at most 15·PRESCALE + 1 cycles.
- Full fade of N steps takes N·FADE_PERIODS periods, measured from the first boundary that sees the new target.
- Simultaneous events:
  - A level change in the same cycle as a boundary uses the old target.
  - The new target is applied at the following boundary.
- level is a same-clock, registered signal. No synchronizer is required.

## Test plan
All scenarios use PRESCALE=2 and FADE_PERIODS=2, so one period is 30 cycles.

1. **Reset:** hold reset_n low for 3 cycles with level=9 → during reset and in the first cycle after release, pwm_out=0, duty=0, busy=0, period_start=0.
2. **Jump to full:** fade_en=0, level 0→15 → busy=1 until the next boundary. Then duty=15, pwm_out held high for the whole of the next 3 periods, and busy=0.
3. **Duty shape:** fade_en=0, level=5 → each period gives pwm_out high for 10 cycles, then low for 20. period_start pulses every 30 cycles, coincident with the rising edge of pwm_out.
4. **Fade up:** fade_en=1, duty=0, level=3 → duty becomes 1, 2, 3 at successive 2nd, 4th, 6th boundaries. busy falls in the same cycle duty reaches 3. No further duty change follows.
5. **Redirect:** fade up toward 12; at duty=6, set level=4 → duty steps 5 then 4, never 7, and stops at 4. Then clear fade_en and set level=10 → duty=10 at the next boundary.
6. **Sync reset mid-fade:** pulse reset_n low for 1 cycle during a fade with duty=7 → at that edge all registers clear. The fade does not resume until target is reloaded and a full period elapses.
